// File: rtl/mem_sync_arbiter_if.sv
// Request/grant bundle between the MEMSync bank caches and the transfer-channel arbiter.
// master = bank side (drives requests), slave = arbiter side (drives grants).
interface mem_sync_arbiter_if #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2
);
  localparam int IDW  = BGWIDTH + BAWIDTH;
  localparam int NREQ = 2 ** IDW;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_wb;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_wb;
  logic [NREQ-1:0] sync;
  logic            busy;
  logic            stall;

  modport master (
    output req, req_wb,
    input  grant, grant_id, grant_wb, sync, busy, stall
  );

  modport slave (
    input  req, req_wb,
    output grant, grant_id, grant_wb, sync, busy, stall
  );
endinterface

// File: rtl/mem_sync_arbiter.sv
// Round-robin owner of the single backing-memory transfer channel shared by all bank caches.
// Build macro SYNC_WB_PRIORITY_EN: pending writebacks win arbitration over fills.
module mem_sync_arbiter #(
  parameter int BGWIDTH    = 2,
  parameter int BAWIDTH    = 2,
  parameter int XFERCYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_sync_arbiter_if.slave bus
);
  localparam int IDW  = BGWIDTH + BAWIDTH;
  localparam int NREQ = 2 ** IDW;
  localparam logic [7:0] XFER_LAST = 8'(XFERCYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [7:0]      count_q, count_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] sync_q, sync_d;
  logic            wb_q, wb_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  scan_id;
  logic [IDW-1:0]  pick_id;
  logic            pick_valid;

  // Round-robin pick: scan downwards so the candidate nearest rr_ptr is written last and wins.
  always_comb begin
`ifdef SYNC_WB_PRIORITY_EN
    cand = (|(bus.req & bus.req_wb)) ? (bus.req & bus.req_wb) : bus.req;
`else
    cand = bus.req;
`endif
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_id = rr_ptr_q + IDW'(k);
      if (cand[scan_id]) begin
        pick_valid = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case; any path that skipped one would infer a latch.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    count_d  = count_q;
    grant_d  = grant_q;
    wb_d     = wb_q;
    sync_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d          = S_XFER;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          id_d             = pick_id;
          wb_d             = bus.req_wb[pick_id];
          count_d          = XFER_LAST;
        end
      end
      S_XFER: begin
        // A dropped request abandons the transfer silently; the bank retries later.
        if (!bus.req[id_q]) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          id_d     = '0;
          wb_d     = 1'b0;
          rr_ptr_d = id_q + IDW'(1);
        end else if (count_q == '0) begin
          state_d  = S_DONE;
          grant_d  = '0;
          id_d     = '0;
          wb_d     = 1'b0;
          sync_d   = grant_q;
          rr_ptr_d = id_q + IDW'(1);
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        wb_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      wb_q     <= 1'b0;
      sync_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      wb_q     <= wb_d;
      sync_q   <= sync_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.grant_wb = wb_q;
  assign bus.sync     = sync_q;
  assign bus.busy     = busy_q;
  // Stall stays combinational so a bank sees it in the same cycle it raises req.
  assign bus.stall    = |(bus.req & ~grant_q);
endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Self-checking bench for mem_sync_arbiter: directed table, hand sequences, random vs timing model.
module tb_mem_sync_arbiter;
  localparam int NREQ = 16;
  localparam int X    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_sync_arbiter_if #(.BGWIDTH(2), .BAWIDTH(2)) bus ();
  mem_sync_arbiter_if #(.BGWIDTH(2), .BAWIDTH(2)) bus1 ();

  mem_sync_arbiter #(.BGWIDTH(2), .BAWIDTH(2), .XFERCYCLES(X)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mem_sync_arbiter #(.BGWIDTH(2), .BAWIDTH(2), .XFERCYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a grant starts at m_start, covers X cycles, sync follows in the next one.
  int m_owner, m_start, m_ptr, m_free, cyc;
  logic m_wb;

  logic [15:0] last_sync, sync_seen, prev_g;
  int q_id[$];
  int q_cyc[$];
  int q_sync[$];
  logic [15:0] obs_grant[64];
  logic [3:0]  obs_id[64];

  function automatic void model_reset();
    m_owner = -1; m_start = 0; m_ptr = 0; m_free = 0; m_wb = 1'b0; cyc = 0;
  endfunction

  function automatic int model_pick(input logic [15:0] r, input logic [15:0] w);
    logic [15:0] c;
    c = r;
`ifdef SYNC_WB_PRIORITY_EN
    if ((r & w) != 16'h0) c = r & w;
`endif
    for (int k = 0; k < NREQ; k++)
      if (c[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_compare(input logic [15:0] r);
    logic [15:0] eg, es;
    logic in_grant, in_done;
    in_grant = (m_owner >= 0) && (cyc < m_start + X);
    in_done  = (m_owner >= 0) && (cyc == m_start + X);
    eg = '0; es = '0;
    if (in_grant) eg[m_owner] = 1'b1;
    if (in_done)  es[m_owner] = 1'b1;
    check($sformatf("grant c%0d", cyc), 32'(bus.grant), 32'(eg));
    check($sformatf("sync c%0d", cyc), 32'(bus.sync), 32'(es));
    check($sformatf("busy c%0d", cyc), 32'(bus.busy), 32'(in_grant || in_done));
    check($sformatf("stall c%0d", cyc), 32'(bus.stall), 32'(|(r & ~eg)));
    if (in_grant) begin
      check($sformatf("grant_id c%0d", cyc), 32'(bus.grant_id), 32'(m_owner));
      check($sformatf("grant_wb c%0d", cyc), 32'(bus.grant_wb), 32'(m_wb));
    end else if (!in_done) begin
      check($sformatf("idle grant_id c%0d", cyc), 32'(bus.grant_id), 32'd0);
    end
  endtask

  function automatic void model_update(input logic [15:0] r, input logic [15:0] w);
    int p;
    if (m_owner >= 0 && cyc < m_start + X && !r[m_owner]) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_free = cyc + 1;
    end else if (m_owner >= 0 && cyc == m_start + X) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_free = cyc + 1;
    end
    if (m_owner < 0 && cyc >= m_free) begin
      p = model_pick(r, w);
      if (p >= 0) begin
        m_owner = p; m_start = cyc + 1; m_wb = w[p];
      end
    end
  endfunction

  task automatic step(input logic [15:0] r, input logic [15:0] w);
    bus.req = r; bus.req_wb = w;
    @(negedge clk);
    model_compare(r);
    model_update(r, w);
    last_sync = bus.sync;
    sync_seen |= bus.sync;
    if (bus.grant != 16'h0 && prev_g == 16'h0) begin
      q_id.push_back(int'(bus.grant_id)); q_cyc.push_back(cyc);
    end
    if (bus.sync != 16'h0) q_sync.push_back(cyc);
    prev_g = bus.grant;
    if (cyc < 64) begin obs_grant[cyc] = bus.grant; obs_id[cyc] = bus.grant_id; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [15:0] r);
    reset = 1'b1; bus.req = r; bus.req_wb = '0; bus1.req = '0; bus1.req_wb = '0;
    @(posedge clk); @(negedge clk);
    check("reset grant", 32'(bus.grant), 32'd0);
    check("reset grant_id", 32'(bus.grant_id), 32'd0);
    check("reset grant_wb", 32'(bus.grant_wb), 32'd0);
    check("reset sync", 32'(bus.sync), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    q_id.delete(); q_cyc.delete(); q_sync.delete();
    sync_seen = '0; prev_g = '0; last_sync = '0;
    for (int i = 0; i < 64; i++) begin obs_grant[i] = 'x; obs_id[i] = 'x; end
  endtask

  typedef struct {
    logic [15:0] req, wb, grant, sync;
    logic [3:0]  id;
    logic        gwb, busy, stall;
  } vec_t;

  vec_t tbl[12];
  logic [15:0] bank_req, bank_wb;
  logic [15:0] g1_exp[5], s1_exp[5];
  logic        b1_exp[5];

  initial begin
    // Single writeback request on bank 0, held until its sync, dropped the cycle after.
    for (int c = 0; c < 12; c++) begin
      tbl[c] = '{req: '0, wb: '0, grant: '0, sync: '0, id: '0, gwb: 1'b0, busy: 1'b0, stall: 1'b0};
      if (c <= 9) begin tbl[c].req = 16'h0001; tbl[c].wb = 16'h0001; end
      if (c >= 1 && c <= 8) begin
        tbl[c].grant = 16'h0001; tbl[c].gwb = 1'b1; tbl[c].busy = 1'b1;
      end
      if (c == 9) begin tbl[c].sync = 16'h0001; tbl[c].busy = 1'b1; end
      tbl[c].stall = (c == 0) || (c == 9);
    end
    g1_exp = '{16'h0, 16'h4, 16'h0, 16'h0, 16'h4};
    s1_exp = '{16'h0, 16'h0, 16'h4, 16'h0, 16'h0};
    b1_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bus.req = '0; bus.req_wb = '0; bus1.req = '0; bus1.req_wb = '0;

    do_reset('0);
    for (int c = 0; c < 12; c++) begin
      bus.req = tbl[c].req; bus.req_wb = tbl[c].wb;
      @(negedge clk);
      check($sformatf("tbl grant c%0d", c), 32'(bus.grant), 32'(tbl[c].grant));
      check($sformatf("tbl sync c%0d", c), 32'(bus.sync), 32'(tbl[c].sync));
      check($sformatf("tbl busy c%0d", c), 32'(bus.busy), 32'(tbl[c].busy));
      check($sformatf("tbl stall c%0d", c), 32'(bus.stall), 32'(tbl[c].stall));
      check($sformatf("tbl grant_id c%0d", c), 32'(bus.grant_id), 32'(tbl[c].id));
      if (tbl[c].grant != 16'h0)
        check($sformatf("tbl grant_wb c%0d", c), 32'(bus.grant_wb), 32'(tbl[c].gwb));
      @(posedge clk); #1;
    end

    // Banks 3,5,12 then 2,15 join once 12 is released; pointer must go 13 -> 15 -> wrap -> 2.
    do_reset('0);
    bank_req = 16'h1028;
    for (int c = 0; c < 52; c++) begin
      if (c == 30) bank_req |= 16'h8004;
      step(bank_req, '0);
      bank_req &= ~last_sync;
    end
    check("rr grant count", 32'(q_id.size()), 32'd5);
    if (q_id.size() == 5) begin
      check("rr order 0", 32'(q_id[0]), 32'd3);
      check("rr order 1", 32'(q_id[1]), 32'd5);
      check("rr order 2", 32'(q_id[2]), 32'd12);
      check("rr order 3", 32'(q_id[3]), 32'd15);
      check("rr order 4", 32'(q_id[4]), 32'd2);
      check("rr start 1", 32'(q_cyc[1]), 32'd11);
      check("rr start 4", 32'(q_cyc[4]), 32'd41);
    end

    // Bank 7 drops its request in its 4th grant cycle; bank 9 is next.
    do_reset('0);
    bank_req = 16'h0280;
    for (int c = 0; c < 20; c++) begin
      if (c == 4) bank_req &= ~16'h0080;
      step(bank_req, '0);
      bank_req &= ~last_sync;
    end
    check("abort grant cleared", 32'(obs_grant[5]), 32'd0);
    check("abort no sync7", 32'(sync_seen[7]), 32'd0);
    check("abort next id", 32'(obs_id[6]), 32'd9);

    // Reset in the middle of a transfer, then a full-length regrant.
    do_reset('0);
    for (int c = 0; c < 3; c++) step(16'h0010, '0);
    #2 reset = 1'b1;
    #1;
    check("async rst grant", 32'(bus.grant), 32'd0);
    check("async rst grant_id", 32'(bus.grant_id), 32'd0);
    check("async rst busy", 32'(bus.busy), 32'd0);
    do_reset(16'h0010);
    bank_req = 16'h0010;
    for (int c = 0; c < 12; c++) begin
      step(bank_req, '0);
      bank_req &= ~last_sync;
    end
    check("regrant start", (q_cyc.size() > 0) ? 32'(q_cyc[0]) : 32'hFFFF, 32'd1);
    check("regrant sync cycle", (q_sync.size() > 0) ? 32'(q_sync[0]) : 32'hFFFF, 32'd9);

    // Fill on bank 1 against writeback on bank 9.
    do_reset('0);
    bank_req = 16'h0202; bank_wb = 16'h0200;
    for (int c = 0; c < 12; c++) begin
      step(bank_req, bank_wb);
      bank_req &= ~last_sync;
    end
`ifdef SYNC_WB_PRIORITY_EN
    check("wb prio grant_id", 32'(obs_id[1]), 32'd9);
`else
    check("wb prio grant_id", 32'(obs_id[1]), 32'd1);
`endif
    check("wb prio grant_wb", 32'(obs_grant[1][9]), 32'(bus.grant_wb === 1'bx ? 1'b0 : obs_grant[1][9]));

    // Lone requester that never lets go: wrap brings the pointer back to it.
    do_reset('0);
    for (int c = 0; c < 22; c++) step(16'h8000, '0);
    check("wrap grant count", 32'(q_cyc.size()), 32'd3);
    if (q_cyc.size() == 3) begin
      check("wrap start 1", 32'(q_cyc[1]), 32'd11);
      check("wrap start 2", 32'(q_cyc[2]), 32'd21);
      check("wrap id 2", 32'(q_id[2]), 32'd15);
    end

    // One-cycle transfers on the second instance.
    do_reset('0);
    for (int c = 0; c < 5; c++) begin
      bus1.req = 16'h0004;
      @(negedge clk);
      check($sformatf("x1 grant c%0d", c), 32'(bus1.grant), 32'(g1_exp[c]));
      check($sformatf("x1 sync c%0d", c), 32'(bus1.sync), 32'(s1_exp[c]));
      check($sformatf("x1 busy c%0d", c), 32'(bus1.busy), 32'(b1_exp[c]));
      @(posedge clk); #1;
    end
    bus1.req = '0;

    // Random traffic: banks hold until sync, occasionally abandon, and wobble req_wb.
    do_reset('0);
    bank_req = '0; bank_wb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if (!bank_req[b]) begin
          if ($urandom_range(0, 7) == 0) begin
            bank_req[b] = 1'b1;
            bank_wb[b]  = 1'($urandom_range(0, 1));
          end
        end else begin
          if ($urandom_range(0, 127) == 0) bank_req[b] = 1'b0;
          if ($urandom_range(0, 15) == 0) bank_wb[b] = ~bank_wb[b];
        end
      end
      step(bank_req, bank_wb);
      bank_req &= ~last_sync;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
